j_pulse_gen: RTL and testbench
==============================

# j_pulse_gen

Parametrised multi-channel pulse/PWM generator for the Jerry audio/DAC path, successor to the single fixed 8-bit compare-and-JK pulse stage. One shared programmable period counter drives CHANNELS independent outputs, each set at a programmable rise compare and cleared at a programmable fall compare. Period and compare values are double-buffered so CPU writes never glitch a running output. A wrap strobe and an optional latched interrupt mark each period boundary.

## Interface
- WIDTH, 8: counter and compare width; also the register data width; must be ≥ CHANNELS+1
- CHANNELS, 2: number of pulse outputs, 1..8
- AW, 4: register address width; 2+2·CHANNELS ≤ 2^AW
- clk  in  1  single system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wr  in  1  register write strobe, one write per cycle
- addr  in  AW  register address
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  combinational readback of addressed register
- pulse  out  CHANNELS  registered pulse outputs
- wrap  out  1  registered one-cycle strobe, high in the cycle the counter reads 0 after a wrap
- irq  out  1  latched period interrupt (0 when PULSE_IRQ_EN absent)
- irq_ack  in  1  clears irq

## Operation
- Registers: 0 CTRL (bit0 global enable, bit k+1 channel k enable); 1 PERIOD; 2+2k RISE_k; 3+2k FALL_k. Unmapped reads return 0, writes ignored.
- PERIOD/RISE/FALL writes go to a shadow copy; rdata returns the shadow. Active copies load from shadow on the edge the counter wraps to 0. While global enable is 0, active copies load every cycle (writes take effect immediately).
- CTRL writes take effect on the next edge, unbuffered.
- Counter: enable=0 → held at 0. enable=1 → increments; at cnt==PERIOD_act next value is 0. Period length PERIOD+1 cycles; PERIOD=0 → counter stays 0, wrap every cycle.
- Per channel k: start = en_k & (cnt==RISE_act); stop = (cnt==FALL_act). JK update: start only → 1; stop only → 0; both → toggle; neither → hold.
- Channel disabled or global enable 0 → pulse_k forced 0 on next edge, overriding JK.
- RISE > FALL → pulse spans the wrap. RISE==FALL → toggles once per period (output at half period rate). RISE > PERIOD → channel never sets; FALL > PERIOD → never clears once set.
- Arithmetic: compares are full-WIDTH equality, counter unsigned, no saturation.

## Timing
- Reset values: counter 0, all shadow/active registers 0, CTRL 0, pulse 0, wrap 0, irq 0.
- pulse changes one cycle after the matching compare cycle: PERIOD=9, RISE=2, FALL=5 → pulse high while cnt reads 3,4,5; 3 of 10 cycles.
- wrap high exactly while cnt==0 following a wrap; not asserted in the first 0 after enable rises.
- Shadow load on wrap edge: new compares apply from cnt==0 of the new period.
- Global enable cleared mid-period: counter 0, pulses 0 next edge; re-enable restarts at cnt 0 with current values.
- Write and wrap in the same cycle: write lands in shadow and is also loaded to active on that edge.
- Reset asserted mid-operation: all outputs 0 immediately (asynchronous).

## Configuration
- PULSE_IRQ_EN defined: irq sets on every wrap strobe, holds until irq_ack; set and ack same cycle → stays set.
- Undefined: irq tied 0, irq_ack ignored, ports remain.

## Structure
- Package j_pulse_pkg: register address constants (REG_CTRL, REG_PERIOD, REG_CH_BASE), CTRL bit positions, JK next-state function.
- Sub-module j_pulse_chan: per-channel shadow/active RISE/FALL, compare and JK flop; instantiated CHANNELS times by generate. Top holds CTRL, PERIOD, counter, wrap, irq, readback mux.

## Test plan
- Reset then read all registers → rdata 0, pulse 0, wrap 0, irq 0.
- PERIOD=9, ch0 RISE=2 FALL=5, enable → pulse[0] high 3 cycles per 10, wrap every 10 cycles.
- ch1 RISE=7 FALL=1, PERIOD=9 → pulse[1] high for cnt 8,9,0,1 (4 cycles), across wrap.
- RISE=FALL=4 → pulse toggles once per 10 cycles (period 20).
- While running write FALL=8 at cnt=3 → current period still clears at 5; next period clears at 8; rdata shows 8 immediately.
- PULSE_IRQ_EN: irq rises with first wrap, irq_ack at the next wrap cycle → irq remains 1; ack alone → 0 next edge; clear enable mid-pulse → pulse 0 next edge, counter 0.

Source files
------------

// File: rtl/j_pulse_pkg.sv
// Shared register map, CTRL bit positions and JK next-state helper for j_pulse_gen.
package j_pulse_pkg;

  localparam int REG_CTRL         = 0;
  localparam int REG_PERIOD       = 1;
  localparam int REG_CH_BASE      = 2;

  localparam int CTRL_GEN_BIT     = 0;
  localparam int CTRL_CH_BASE_BIT = 1;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b10:   r = 1'b1;
      2'b01:   r = 1'b0;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/j_pulse_chan.sv
// One pulse channel: double-buffered RISE/FALL compares driving a JK output flop.
module j_pulse_chan
  import j_pulse_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_wr_rise,
  input  logic             i_wr_fall,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_cnt,
  output logic [WIDTH-1:0] o_rise_sh,
  output logic [WIDTH-1:0] o_fall_sh,
  output logic             o_pulse
);

  logic [WIDTH-1:0] r_rise_sh, r_rise_act, r_fall_sh, r_fall_act;
  logic             r_pulse;
  logic [WIDTH-1:0] w_rise_nxt, w_fall_nxt;
  logic             w_start, w_stop;

  // A write landing on the load edge must reach the active copy too.
  assign w_rise_nxt = i_wr_rise ? i_wdata : r_rise_sh;
  assign w_fall_nxt = i_wr_fall ? i_wdata : r_fall_sh;
  assign w_start    = (i_cnt == r_rise_act);
  assign w_stop     = (i_cnt == r_fall_act);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rise_sh  <= '0;
      r_rise_act <= '0;
      r_fall_sh  <= '0;
      r_fall_act <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_rise_sh <= w_rise_nxt;
      r_fall_sh <= w_fall_nxt;
      if (i_load) begin
        r_rise_act <= w_rise_nxt;
        r_fall_act <= w_fall_nxt;
      end
      r_pulse <= i_run ? jk_next(r_pulse, w_start, w_stop) : 1'b0;
    end
  end

  assign o_rise_sh = r_rise_sh;
  assign o_fall_sh = r_fall_sh;
  assign o_pulse   = r_pulse;

endmodule

// File: rtl/j_pulse_gen.sv
// Multi-channel pulse/PWM generator: shared period counter, CTRL/PERIOD regs, wrap strobe.
// Optional latched period interrupt enabled by defining PULSE_IRQ_EN.
module j_pulse_gen
  import j_pulse_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int AW       = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr,
  input  logic [AW-1:0]       i_addr,
  input  logic [WIDTH-1:0]    i_wdata,
  output logic [WIDTH-1:0]    o_rdata,
  output logic [CHANNELS-1:0] o_pulse,
  output logic                o_wrap,
  output logic                o_irq,
  input  logic                i_irq_ack
);

  logic [WIDTH-1:0] r_ctrl, r_period_sh, r_period_act, r_cnt;
  logic             r_wrap;
  logic             w_en, w_at_end, w_load, w_wr_period;
  logic [WIDTH-1:0] w_period_nxt;
  logic [WIDTH-1:0] w_rise_sh [CHANNELS];
  logic [WIDTH-1:0] w_fall_sh [CHANNELS];

  assign w_en         = r_ctrl[CTRL_GEN_BIT];
  assign w_at_end     = (r_cnt == r_period_act);
  // Active copies track the shadows continuously while stopped, else only on wrap.
  assign w_load       = ~w_en | w_at_end;
  assign w_wr_period  = i_wr && (i_addr == AW'(REG_PERIOD));
  assign w_period_nxt = w_wr_period ? i_wdata : r_period_sh;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl       <= '0;
      r_period_sh  <= '0;
      r_period_act <= '0;
      r_cnt        <= '0;
      r_wrap       <= 1'b0;
    end else begin
      if (i_wr && (i_addr == AW'(REG_CTRL))) r_ctrl <= i_wdata;
      r_period_sh <= w_period_nxt;
      if (w_load) r_period_act <= w_period_nxt;
      r_cnt  <= (w_en && !w_at_end) ? r_cnt + 1'b1 : '0;
      r_wrap <= w_en & w_at_end;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    j_pulse_chan #(.WIDTH(WIDTH)) u_chan (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load),
      .i_run     (w_en & r_ctrl[CTRL_CH_BASE_BIT + k]),
      .i_wr_rise (i_wr && (i_addr == AW'(REG_CH_BASE + 2*k))),
      .i_wr_fall (i_wr && (i_addr == AW'(REG_CH_BASE + 2*k + 1))),
      .i_wdata   (i_wdata),
      .i_cnt     (r_cnt),
      .o_rise_sh (w_rise_sh[k]),
      .o_fall_sh (w_fall_sh[k]),
      .o_pulse   (o_pulse[k])
    );
  end

  always_comb begin
    o_rdata = '0;
    if (i_addr == AW'(REG_CTRL))   o_rdata = r_ctrl;
    if (i_addr == AW'(REG_PERIOD)) o_rdata = r_period_sh;
    for (int k = 0; k < CHANNELS; k++) begin
      if (i_addr == AW'(REG_CH_BASE + 2*k))     o_rdata = w_rise_sh[k];
      if (i_addr == AW'(REG_CH_BASE + 2*k + 1)) o_rdata = w_fall_sh[k];
    end
  end

`ifdef PULSE_IRQ_EN
  logic r_irq;
  // A pending strobe wins over a simultaneous ack.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_irq <= 1'b0;
    else         r_irq <= r_wrap | (r_irq & ~i_irq_ack);
  end
  assign o_irq = r_irq;
`else
  logic w_unused_irq_ack;
  assign w_unused_irq_ack = i_irq_ack;
  assign o_irq = 1'b0;
`endif

  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_j_pulse_gen.sv
// Randomized + directed bench for j_pulse_gen against a behavioural register/counter model.
module tb_j_pulse_gen;
  localparam int W = 8, CH = 2, AW = 4;

  logic          clk = 1'b0, rst;
  logic          wr, ack;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata, rdata;
  logic [CH-1:0] pulse;
  logic          wrap, irq;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  j_pulse_gen #(.WIDTH(W), .CHANNELS(CH), .AW(AW)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_pulse(pulse), .o_wrap(wrap), .o_irq(irq), .i_irq_ack(ack)
  );

  // Model state: registers as plain integers, counter position within the period.
  int m_ctrl, m_per_sh, m_per_act, m_cnt, m_wrap, m_irq;
  int m_rise_sh[CH], m_rise_act[CH], m_fall_sh[CH], m_fall_act[CH], m_pulse[CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_rdata(input int a);
    if (a == 0) return m_ctrl;
    if (a == 1) return m_per_sh;
    for (int c = 0; c < CH; c++) begin
      if (a == 2 + 2*c) return m_rise_sh[c];
      if (a == 3 + 2*c) return m_fall_sh[c];
    end
    return 0;
  endfunction

  function automatic int m_pvec();
    int v = 0;
    for (int c = 0; c < CH; c++) v |= m_pulse[c] << c;
    return v;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_per_sh = 0; m_per_act = 0; m_cnt = 0; m_wrap = 0; m_irq = 0;
    for (int c = 0; c < CH; c++) begin
      m_rise_sh[c] = 0; m_rise_act[c] = 0; m_fall_sh[c] = 0; m_fall_act[c] = 0; m_pulse[c] = 0;
    end
  endtask

  task automatic model_step(input bit w, input int a, input int d, input bit k);
    bit en   = (m_ctrl & 1) != 0;
    bit endp = (m_cnt == m_per_act);
    bit s, t;
    d = d & 255;
    for (int c = 0; c < CH; c++) begin
      if (!en || ((m_ctrl >> (c + 1)) & 1) == 0) m_pulse[c] = 0;
      else begin
        s = (m_cnt == m_rise_act[c]);
        t = (m_cnt == m_fall_act[c]);
        if (s && t) m_pulse[c] = 1 - m_pulse[c];
        else if (s) m_pulse[c] = 1;
        else if (t) m_pulse[c] = 0;
      end
    end
`ifdef PULSE_IRQ_EN
    m_irq = (m_wrap != 0 || (m_irq != 0 && !k)) ? 1 : 0;
`endif
    m_wrap = (en && endp) ? 1 : 0;
    m_cnt  = (en && !endp) ? ((m_cnt + 1) & 255) : 0;
    if (w) begin
      if (a == 0) m_ctrl = d;
      if (a == 1) m_per_sh = d;
      for (int c = 0; c < CH; c++) begin
        if (a == 2 + 2*c) m_rise_sh[c] = d;
        if (a == 3 + 2*c) m_fall_sh[c] = d;
      end
    end
    if (!en || endp) begin
      m_per_act = m_per_sh;
      for (int c = 0; c < CH; c++) begin
        m_rise_act[c] = m_rise_sh[c];
        m_fall_act[c] = m_fall_sh[c];
      end
    end
  endtask

  // Drive one cycle from a negedge, check readback, advance, check outputs at next negedge.
  task automatic step(input bit w, input int a, input int d, input bit k);
    wr = w; addr = a[AW-1:0]; wdata = d[W-1:0]; ack = k;
    #1 chk("rdata", rdata, m_rdata(a));
    model_step(w, a, d, k);
    @(posedge clk);
    @(negedge clk);
    chk("pulse", pulse, m_pvec());
    chk("wrap", wrap, m_wrap);
    chk("irq", irq, m_irq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  int c0, c1, cw;
  bit found;

  initial begin
    rst = 1'b1; wr = 1'b0; addr = '0; wdata = '0; ack = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_pulse", pulse, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_irq", irq, 0);
    for (int a = 0; a < 16; a++) begin
      addr = a[AW-1:0];
      #1 chk("rst_rdata", rdata, 0);
    end
    rst = 1'b0;

    // PERIOD=9, ch0 2->5, ch1 7->1 (spans wrap), all enabled
    step(1, 1, 9, 0); step(1, 2, 2, 0); step(1, 3, 5, 0);
    step(1, 4, 7, 0); step(1, 5, 1, 0); step(1, 0, 7, 0);
    chk("first_zero_wrap", wrap, 0);
    idle(10);
    c0 = 0; c1 = 0; cw = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      c0 += pulse[0]; c1 += pulse[1]; cw += wrap;
    end
    chk("p0_duty", c0, 3);
    chk("p1_duty", c1, 4);
    chk("wrap_per10", cw, 1);

`ifdef PULSE_IRQ_EN
    found = 0;
    for (int i = 0; i < 30 && !found; i++) if (m_wrap != 0) found = 1; else step(0, 0, 0, 0);
    chk("wait_wrap", found, 1);
    step(0, 0, 0, 1);
    chk("irq_ack_on_wrap", irq, 1);
    step(0, 0, 0, 1);
    chk("irq_ack_alone", irq, 0);
`endif

    // FALL0 rewritten mid-period: shadow visible now, active at next wrap
    found = 0;
    for (int i = 0; i < 30 && !found; i++) if (m_cnt == 3) found = 1; else step(0, 0, 0, 0);
    chk("wait_cnt3", found, 1);
    step(1, 3, 8, 0);
    addr = 4'd3;
    #1 chk("fall_shadow_rd", rdata, 8);
    idle(25);

    // RISE==FALL: toggles once per period
    step(1, 2, 4, 0); step(1, 3, 4, 0);
    idle(20);
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      c0 += pulse[0];
    end
    chk("toggle_duty", c0, 10);

    // Disable while ch1 high
    found = 0;
    for (int i = 0; i < 30 && !found; i++) if (pulse[1]) found = 1; else step(0, 0, 0, 0);
    chk("wait_p1", found, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("disable_pulse", pulse, 0);
    step(1, 0, 7, 0);
    idle(12);

    // Asynchronous reset mid-run
    found = 0;
    for (int i = 0; i < 30 && !found; i++) if (pulse != 0) found = 1; else step(0, 0, 0, 0);
    chk("wait_any_pulse", found, 1);
    rst = 1'b1; addr = 4'd1;
    #1;
    chk("async_pulse", pulse, 0);
    chk("async_period", rdata, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 800; i++) begin
      int a, d;
      bit w, k;
      w = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 15);
      if (a == 0) d = $urandom_range(0, 7) | (($urandom_range(0, 4) != 0) ? 1 : 0);
      else if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 255);
      else d = $urandom_range(0, 12);
      k = ($urandom_range(0, 2) == 0);
      step(w, a, d, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
